qs_enq: RTL and testbench

//  Ingress stage of the quicksort engine; sits directly upstream of the sorter and dequeue stages.

---
 rtl/qs_pkg.sv | 34 +++
 rtl/qs_enq.sv | 156 +++++++++++++++
 tb/tb_qs_enq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qs_pkg.sv
// qs_pkg: shared widths, bank scoreboard types and helpers for the quicksort engine.
package qs_pkg;

  localparam int unsigned W         = 16;
  localparam int unsigned N         = 16;
  localparam int unsigned BANKS_N   = 4;
  localparam int unsigned ADDR_W    = $clog2(N);
  localparam int unsigned BANK_ID_W = $clog2(BANKS_N);

  typedef logic [W-1:0]         w_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [BANK_ID_W-1:0] bank_id_t;

  typedef enum logic [2:0] {
    BANK_READY     = 3'd0,
    BANK_LOADING   = 3'd1,
    BANK_LOADED    = 3'd2,
    BANK_SORTING   = 3'd3,
    BANK_SORTED    = 3'd4,
    BANK_UNLOADING = 3'd5
  } bank_status_t;

  // n is the index of the last valid word in the bank
  typedef struct packed {
    bank_status_t status;
    addr_t        n;
  } bank_state_t;

  function automatic bank_id_t bank_id_inc(input bank_id_t id);
    if (id == bank_id_t'(BANKS_N - 1)) return '0;
    return id + bank_id_t'(1);
  endfunction

endpackage

// File: rtl/qs_enq.sv
// qs_enq: ingress stage of the quicksort engine; loads sop..eop packets into round-robin banks.
// Define QS_ENQ_STATS_EN to add saturating pkt_cnt_r / drop_cnt_r counters.
module qs_enq
  import qs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic        in_sop,
  input  logic        in_eop,
  input  w_t          in_dat,
  output logic        in_rdy,
  output bank_id_t    bank_idx_r,
  input  bank_state_t bank_in,
  output logic        bank_out_vld,
  output bank_state_t bank_out,
  output logic        wr_en_r,
  output addr_t       wr_addr_r,
  output w_t          wr_data_r
`ifdef QS_ENQ_STATS_EN
  ,
  output logic [31:0] pkt_cnt_r,
  output logic [31:0] drop_cnt_r
`endif
);

  // MSB is the busy bit: set while a packet owns the current bank.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LOAD    = 2'b10,
    ST_DISCARD = 2'b11
  } fsm_e;

  localparam addr_t ADDR_LAST = addr_t'(N - 1);

  fsm_e     state_q, state_d;
  bank_id_t bank_idx_q, bank_idx_d;
  addr_t    wr_ptr_q, wr_ptr_d;
  logic     wr_en_q, wr_en_d;
  addr_t    wr_addr_q, wr_addr_d;
  w_t       wr_data_q, wr_data_d;
  logic     acc;
  logic     at_last;

  assign in_rdy  = !rst && (state_q[1] || (bank_in.status == BANK_READY));
  assign acc     = in_vld && in_rdy;
  assign at_last = (wr_ptr_q == ADDR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc && in_sop && !in_eop) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (acc) begin
          if (in_sop)       state_d = in_eop ? ST_IDLE : ST_LOAD;
          else if (in_eop)  state_d = ST_IDLE;
          else if (at_last) state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (acc && in_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scoreboard write-back and memory write decisions for the accepted word
  always_comb begin
    bank_out_vld = 1'b0;
    bank_out     = bank_in;
    bank_idx_d   = bank_idx_q;
    wr_ptr_d     = wr_ptr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (acc) begin
      if (in_sop && (state_q != ST_DISCARD)) begin
        wr_en_d      = 1'b1;
        wr_addr_d    = '0;
        wr_data_d    = in_dat;
        wr_ptr_d     = '0;
        bank_out_vld = 1'b1;
        if (in_eop) begin
          bank_out.status = BANK_LOADED;
          bank_out.n      = '0;
          bank_idx_d      = bank_id_inc(bank_idx_q);
        end else begin
          bank_out.status = BANK_LOADING;
        end
      end else if ((state_q == ST_LOAD) && !at_last) begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_ptr_q + addr_t'(1);
        wr_data_d = in_dat;
        wr_ptr_d  = wr_addr_d;
        if (in_eop) begin
          bank_out_vld    = 1'b1;
          bank_out.status = BANK_LOADED;
          bank_out.n      = wr_addr_d;
          bank_idx_d      = bank_id_inc(bank_idx_q);
        end
      end else if ((state_q != ST_IDLE) && in_eop) begin
        // overflowed packet ends: hand the bank back untouched
        bank_out_vld    = 1'b1;
        bank_out.status = BANK_READY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_idx_q <= '0;
      wr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      bank_idx_q <= bank_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bank_idx_r = bank_idx_q;
  assign wr_en_r    = wr_en_q;
  assign wr_addr_r  = wr_addr_q;
  assign wr_data_r  = wr_data_q;

`ifdef QS_ENQ_STATS_EN
  logic pkt_inc;
  logic drop_inc;

  assign pkt_inc  = bank_out_vld && (bank_out.status == BANK_LOADED);
  assign drop_inc = acc && !in_sop &&
                    ((state_q == ST_IDLE) || ((state_q == ST_LOAD) && at_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_r  <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (pkt_inc && (pkt_cnt_r != '1))   pkt_cnt_r  <= pkt_cnt_r + 32'd1;
      if (drop_inc && (drop_cnt_r != '1)) drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qs_enq.sv
// tb_qs_enq: randomized bench for qs_enq against a packet-level reference model.
// Honors QS_ENQ_STATS_EN to also check the statistics counters.
module tb_qs_enq;
  import qs_pkg::*;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  w_t          in_dat = '0;
  logic        in_rdy;
  bank_id_t    bank_idx_r;
  bank_state_t bank_in;
  logic        bank_out_vld;
  bank_state_t bank_out;
  logic        wr_en_r;
  addr_t       wr_addr_r;
  w_t          wr_data_r;
`ifdef QS_ENQ_STATS_EN
  logic [31:0] pkt_cnt_r;
  logic [31:0] drop_cnt_r;
`endif

  qs_enq u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_dat      (in_dat),
    .in_rdy      (in_rdy),
    .bank_idx_r  (bank_idx_r),
    .bank_in     (bank_in),
    .bank_out_vld(bank_out_vld),
    .bank_out    (bank_out),
    .wr_en_r     (wr_en_r),
    .wr_addr_r   (wr_addr_r),
    .wr_data_r   (wr_data_r)
`ifdef QS_ENQ_STATS_EN
    ,
    .pkt_cnt_r   (pkt_cnt_r),
    .drop_cnt_r  (drop_cnt_r)
`endif
  );

  always #5 clk = ~clk;

  // Bank scoreboard emulated by the bench
  bank_state_t bank_st [BANKS_N];
  assign bank_in = bank_st[bank_idx_r];

  int total = 0;
  int bad   = 0;

  // Reference model: packet progress and expected counters
  bit    m_busy;
  bit    m_disc;
  int    m_len;
  int    m_bank;
  int    exp_pkts;
  int    exp_drops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic all_ready();
    for (int b = 0; b < int'(BANKS_N); b++)
      if (!(m_busy && b == m_bank)) bank_st[b].status = BANK_READY;
  endtask

  // Consumer side: loaded banks get sorted and eventually freed
  task automatic env_release();
    for (int b = 0; b < int'(BANKS_N); b++) begin
      if (bank_st[b].status == BANK_LOADED && ($urandom % 3) == 0)
        bank_st[b].status = BANK_SORTING;
      else if (bank_st[b].status == BANK_SORTING && ($urandom % 4) == 0)
        bank_st[b].status = BANK_READY;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    #2;
    check("rst_wr_en",    32'(wr_en_r), 32'd0);
    check("rst_wr_addr",  32'(wr_addr_r), 32'd0);
    check("rst_wr_data",  32'(wr_data_r), 32'd0);
    check("rst_bank_idx", 32'(bank_idx_r), 32'd0);
    check("rst_in_rdy",   32'(in_rdy), 32'd0);
    check("rst_bank_vld", 32'(bank_out_vld), 32'd0);
`ifdef QS_ENQ_STATS_EN
    check("rst_pkt_cnt",  pkt_cnt_r, 32'd0);
    check("rst_drop_cnt", drop_cnt_r, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_busy    = 1'b0;
    m_disc    = 1'b0;
    m_len     = 0;
    m_bank    = 0;
    exp_pkts  = 0;
    exp_drops = 0;
    for (int b = 0; b < int'(BANKS_N); b++) begin
      bank_st[b].status = BANK_READY;
      bank_st[b].n      = '0;
    end
  endtask

  // One clock: drive a word, predict acceptance and results, check both edges of latency
  task automatic step(input logic v, input logic s, input logic e, input w_t d);
    logic        exp_rdy;
    logic        acc;
    logic        exp_bvld;
    logic        exp_we;
    addr_t       exp_addr;
    w_t          exp_data;
    bank_state_t exp_bst;
    int          idx;
    int          bank_now;
    in_vld = v;
    in_sop = s;
    in_eop = e;
    in_dat = d;
    #3;
    bank_now = m_bank;
    exp_rdy  = m_busy || (bank_st[m_bank].status == BANK_READY);
    check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    acc      = v && exp_rdy;
    exp_bvld = 1'b0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_bst  = bank_st[m_bank];
    if (acc) begin
      if (s && !(m_busy && m_disc)) begin
        m_busy = 1'b1;
        m_disc = 1'b0;
        m_len  = 0;
      end
      if (!m_busy) begin
        exp_drops++;
      end else begin
        idx = m_len;
        m_len++;
        if (!m_disc && idx < int'(N)) begin
          exp_we   = 1'b1;
          exp_addr = addr_t'(idx);
          exp_data = d;
        end else if (!m_disc) begin
          m_disc = 1'b1;
          exp_drops++;
        end
        if (e) begin
          exp_bvld = 1'b1;
          if (m_disc) begin
            exp_bst.status = BANK_READY;
          end else begin
            exp_bst.status = BANK_LOADED;
            exp_bst.n      = addr_t'(idx);
            m_bank         = (m_bank + 1) % int'(BANKS_N);
            exp_pkts++;
          end
          m_busy = 1'b0;
        end else if (idx == 0) begin
          exp_bvld       = 1'b1;
          exp_bst.status = BANK_LOADING;
        end
      end
    end
    check("bank_out_vld", 32'(bank_out_vld), 32'(exp_bvld));
    if (exp_bvld) check("bank_out", 32'(bank_out), 32'(exp_bst));
    @(posedge clk);
    #1;
    if (exp_bvld) bank_st[bank_now] = exp_bst;
    check("wr_en_r", 32'(wr_en_r), 32'(exp_we));
    if (exp_we) begin
      check("wr_addr_r", 32'(wr_addr_r), 32'(exp_addr));
      check("wr_data_r", 32'(wr_data_r), 32'(exp_data));
    end
    check("bank_idx_r", 32'(bank_idx_r), 32'(m_bank));
`ifdef QS_ENQ_STATS_EN
    check("pkt_cnt_r",  pkt_cnt_r,  32'(exp_pkts));
    check("drop_cnt_r", drop_cnt_r, 32'(exp_drops));
`endif
  endtask

  initial begin
    #1;
    do_reset();

    // 4-word packet, then single-word packet
    step(1'b1, 1'b1, 1'b0, w_t'('hA));
    step(1'b1, 1'b0, 1'b0, w_t'('hB));
    step(1'b1, 1'b0, 1'b0, w_t'('hC));
    step(1'b1, 1'b0, 1'b1, w_t'('hD));
    step(1'b1, 1'b1, 1'b1, w_t'('h55));

    // Target bank busy sorting: backpressure until freed
    bank_st[m_bank].status = BANK_SORTING;
    repeat (4) step(1'b1, 1'b1, 1'b0, w_t'('h77));
    bank_st[m_bank].status = BANK_READY;

    // Orphan word, then a valid packet
    step(1'b1, 1'b0, 1'b0, w_t'('h99));
    step(1'b1, 1'b1, 1'b0, w_t'('h1));
    step(1'b1, 1'b0, 1'b1, w_t'('h2));

    // N+2-word packet overflows the bank
    all_ready();
    for (int i = 0; i < int'(N) + 2; i++)
      step(1'b1, 1'b1 * (i == 0), 1'b1 * (i == int'(N) + 1), w_t'(100 + i));

    // Exactly N words is legal
    for (int i = 0; i < int'(N); i++)
      step(1'b1, 1'b1 * (i == 0), 1'b1 * (i == int'(N) - 1), w_t'(200 + i));

    // sop mid-packet restarts in the same bank
    all_ready();
    step(1'b0, 1'b0, 1'b0, w_t'('h0));
    step(1'b1, 1'b1, 1'b0, w_t'('h11));
    step(1'b1, 1'b0, 1'b0, w_t'('h12));
    step(1'b1, 1'b1, 1'b0, w_t'('h13));
    step(1'b1, 1'b0, 1'b1, w_t'('h14));

    // Reset in the middle of a packet
    all_ready();
    step(1'b1, 1'b1, 1'b0, w_t'('h21));
    step(1'b1, 1'b0, 1'b0, w_t'('h22));
    do_reset();

    // Five back-to-back packets walk the banks round-robin
    for (int p = 0; p < 5; p++) begin
      if (p == 4) all_ready();
      step(1'b1, 1'b1, 1'b0, w_t'(p * 16));
      step(1'b1, 1'b0, 1'b1, w_t'(p * 16 + 1));
    end

    // Random traffic against a randomly draining scoreboard
    all_ready();
    for (int t = 0; t < 2500; t++) begin
      step(1'b1 * (($urandom % 4) != 0), 1'b1 * (($urandom % 8) == 0),
           1'b1 * (($urandom % 9) == 0), w_t'($urandom));
      env_release();
    end

    $display("info: packets=%0d drops=%0d", exp_pkts, exp_drops);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
